// File: rtl/dma_tx_wrr_arb.sv
// Weighted round-robin token arbiter for the DMA TX path.
// Grants one requesting channel at a time and holds the registered token for
// up to weight[ch] acknowledged transfers, then rotates priority past the
// released channel. A release hands over to the next requester back-to-back.
module dma_tx_wrr_arb #(
  parameter int  N     = 4,
  parameter int  WGT_W = 4,
  localparam int ID_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               user_clk,
  input  logic               reset_n,
  input  logic [N-1:0]       req,
  input  logic [N*WGT_W-1:0] weight,
  input  logic               tkn_ack,
  output logic [N-1:0]       tkn,
  output logic               tkn_vld,
  output logic [ID_W-1:0]    tkn_id
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [WGT_W-1:0]  credit, credit_nxt;
  logic [N-1:0]      tkn_nxt;
  logic [ID_W-1:0]   tkn_id_nxt;

  // Arbitration helpers
  logic [ID_W-1:0]   rel_ptr;     // pointer value after releasing the current grant
  logic [ID_W-1:0]   scan_start;
  logic [N-1:0]      cand;
  logic              pick_found;
  logic [ID_W-1:0]   pick_win;
  logic [N-1:0]      pick_oh;
  logic [WGT_W-1:0]  pick_wgt;
  logic              release_now;

  assign rel_ptr = ID_W'((int'(tkn_id) + 1) % N);

  // A grant ends on its last acknowledged transfer, or as soon as the owner drops its request.
  assign release_now = (tkn_ack && (credit == WGT_W'(1))) || !req[tkn_id];

  // Rotating-priority scan: first candidate at or after scan_start, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cand       = (state == GRANT) ? (req & ~tkn) : req;
    scan_start = (state == GRANT) ? rel_ptr : ptr;
    pick_found = 1'b0;
    pick_win   = '0;
    for (int k = 0; k < N; k++) begin
      if (!pick_found && cand[(int'(scan_start) + k) % N]) begin
        pick_found = 1'b1;
        pick_win   = ID_W'((int'(scan_start) + k) % N);
      end
    end
    pick_oh           = '0;
    pick_oh[pick_win] = 1'b1;
    pick_wgt          = weight[int'(pick_win)*WGT_W +: WGT_W];
    // A zero weight still earns one transfer, which also keeps credit from underflowing.
    if (pick_wgt == '0) pick_wgt = WGT_W'(1);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    credit_nxt = credit;
    tkn_nxt    = tkn;
    tkn_id_nxt = tkn_id;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt  = GRANT;
          tkn_nxt    = pick_oh;
          tkn_id_nxt = pick_win;
          credit_nxt = pick_wgt;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_nxt = rel_ptr;
          if (pick_found) begin
            tkn_nxt    = pick_oh;
            tkn_id_nxt = pick_win;
            credit_nxt = pick_wgt;
          end else begin
            state_nxt  = IDLE;
            tkn_nxt    = '0;
            tkn_id_nxt = '0;
            credit_nxt = '0;
          end
        end else if (tkn_ack) begin
          credit_nxt = credit - WGT_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        tkn_nxt    = '0;
        tkn_id_nxt = '0;
        credit_nxt = '0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge user_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= '0;
      credit  <= '0;
      tkn     <= '0;
      tkn_vld <= 1'b0;
      tkn_id  <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      credit  <= credit_nxt;
      tkn     <= tkn_nxt;
      tkn_vld <= |tkn_nxt;
      tkn_id  <= tkn_id_nxt;
    end
  end

endmodule
